// File: rtl/approx_add_pkg.sv
// Shared types and constants for the pipelined approximate adder family.
package approx_add_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Payload fields are sized for the widest supported operand; users slice the low bits.
    localparam int unsigned PAYLOAD_W = 64;

    function automatic int unsigned upper_width(input int unsigned w, input int unsigned k);
        return w - k;
    endfunction

    typedef struct packed {
        logic [PAYLOAD_W-1:0] lo;
        logic                 c;
        logic [PAYLOAD_W-1:0] a_u;
        logic [PAYLOAD_W-1:0] b_u;
        logic                 mode;
    } s1_payload_t;

endpackage

// File: rtl/approx_add_lower.sv
// Combinational K-bit low part: lower-part-OR in approximate mode, exact add otherwise.
module approx_add_lower
    import approx_add_pkg::*;
#(
    parameter int unsigned K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         approx,
    output logic [K-1:0] l,
    output logic         c
);

    logic [K:0] exact_sum;

    always_comb begin
        exact_sum = {1'b0, a} + {1'b0, b};
        l         = exact_sum[K-1:0];
        c         = exact_sum[K];
        if (approx == MODE_APPROX) begin
            l = a | b;
            c = a[K-1] & b[K-1];
        end
    end

endmodule

// File: rtl/approx_add_pipe.sv
// Two-stage valid/ready approximate adder. Define ERR_MON_EN to add the error monitor ports.
module approx_add_pipe
    import approx_add_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
`ifdef ERR_MON_EN
    output logic [WIDTH:0]   err_abs,
    output logic [31:0]      err_cnt,
    output logic [WIDTH:0]   err_max,
`endif
    output logic             out_approx
);

    localparam int unsigned UW = upper_width(WIDTH, APPROX_BITS);
    localparam int unsigned LW = (APPROX_BITS > 0) ? APPROX_BITS : 1;
    localparam int unsigned SW = WIDTH + 1;

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    s1_payload_t       s1_q, s1_d;
    logic [WIDTH:0]    out_sum_q, out_sum_d;
    logic              out_approx_q, out_approx_d;

    logic              s1_load, s2_load, accept;
    logic [LW-1:0]     lo_w;
    logic              c_w;
    logic [UW:0]       sum_u;
    logic              unused_payload;

    approx_add_lower #(.K(LW)) u_lower (
        .a      (in_a[LW-1:0]),
        .b      (in_b[LW-1:0]),
        .approx (in_approx == MODE_APPROX),
        .l      (lo_w),
        .c      (c_w)
    );

    assign unused_payload = ^s1_q;

    always_comb begin
        s2_load    = !s2_valid_q || out_ready;
        s1_load    = !s1_valid_q || s2_load;
        accept     = in_valid && s1_load;
        in_ready   = s1_load;

        s1_valid_d = s1_load ? in_valid : s1_valid_q;
        s1_d       = s1_q;
        if (accept) begin
            s1_d = '0;
            // With no approximated bits the low part vanishes and the carry-in is zero.
            if (APPROX_BITS > 0) begin
                s1_d.lo[LW-1:0] = lo_w;
                s1_d.c          = c_w;
            end
            s1_d.a_u[UW-1:0] = in_a[WIDTH-1:APPROX_BITS];
            s1_d.b_u[UW-1:0] = in_b[WIDTH-1:APPROX_BITS];
            s1_d.mode        = in_approx;
        end

        sum_u = {1'b0, s1_q.a_u[UW-1:0]} + {1'b0, s1_q.b_u[UW-1:0]} + {{UW{1'b0}}, s1_q.c};

        s2_valid_d   = s2_load ? s1_valid_q : s2_valid_q;
        out_sum_d    = out_sum_q;
        out_approx_d = out_approx_q;
        if (s2_load && s1_valid_q) begin
            out_sum_d    = (SW'(sum_u) << APPROX_BITS) | SW'(s1_q.lo[LW-1:0]);
            out_approx_d = s1_q.mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s1_q         <= '0;
            out_sum_q    <= '0;
            out_approx_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s1_q         <= s1_d;
            out_sum_q    <= out_sum_d;
            out_approx_q <= out_approx_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_sum    = out_sum_q;
    assign out_approx = out_approx_q;

`ifdef ERR_MON_EN
    logic [WIDTH:0] ex1_q, ex1_d;
    logic [WIDTH:0] ex2_q, ex2_d;
    logic [31:0]    err_cnt_q, err_cnt_d;
    logic [WIDTH:0] err_max_q, err_max_d;

    always_comb begin
        ex1_d = accept ? (SW'(in_a) + SW'(in_b)) : ex1_q;
        ex2_d = (s2_load && s1_valid_q) ? ex1_q : ex2_q;

        err_abs = (out_sum_q >= ex2_q) ? (out_sum_q - ex2_q) : (ex2_q - out_sum_q);

        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        if (s2_valid_q && out_ready) begin
            if ((err_abs != '0) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end
            if (err_abs > err_max_q) begin
                err_max_d = err_abs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex1_q     <= '0;
            ex2_q     <= '0;
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else begin
            ex1_q     <= ex1_d;
            ex2_q     <= ex2_d;
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_max = err_max_q;
`endif

endmodule
